// File: rtl/speech_pkg.sv
// Shared types and width helpers for the speech frame feeder.
// Holds the FSM state encoding and the compile-time width derivations.
package speech_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        PRESENT,
        DONE
    } state_t;

    function automatic int calc_bytes(input int sample_w, input int ram_w);
        return sample_w / ram_w;
    endfunction

    // ceil(log2(n)), never below 1 so a counter always has at least one bit
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sample_assembler.sv
// Little-endian byte-to-sample shift register: each load shifts a byte in at the top.
// After BYTES loads, the first byte sits in the least significant lane; holds when load is low.
module sample_assembler
    import speech_pkg::*;
#(
    parameter int RAM_W = 8,
    parameter int BYTES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [RAM_W-1:0]         din,
    output logic [RAM_W*BYTES-1:0]   dout
);

    logic [RAM_W*BYTES-1:0] sreg;

    generate
        if (BYTES == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sreg <= '0;
                end else if (load) begin
                    sreg <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sreg <= '0;
                end else if (load) begin
                    sreg <= {din, sreg[RAM_W*BYTES-1:RAM_W]};
                end
            end
        end
    endgenerate

    assign dout = sreg;

endmodule

// File: rtl/frame_feeder.sv
// Streams overlapping frames of multi-byte samples from a byte-wide speech RAM.
// Sample valid BYTES+1 cycles after start/handshake; stalls (no RAM reads) while sample_ready is low.
module frame_feeder
    import speech_pkg::*;
#(
    parameter int RAM_W     = 8,
    parameter int SAMPLE_W  = 16,
    parameter int ADDR_W    = 16,
    parameter int FRAME_LEN = 160,
    parameter int HOP       = 80,
    parameter int FCNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [FCNT_W-1:0]   num_frames,
    output logic                ram_rd,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [RAM_W-1:0]    ram_datain,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                frame_first,
    output logic                frame_last,
    output logic                busy,
    output logic                done
);

    localparam int BYTES = calc_bytes(SAMPLE_W, RAM_W);
    localparam int KW    = cnt_width(FRAME_LEN);
    localparam int BW    = cnt_width(BYTES);

    localparam logic [ADDR_W-1:0] SAMP_STEP = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] HOP_STEP  = ADDR_W'(HOP * BYTES);

    state_t            state;
    logic [ADDR_W-1:0] frame_addr;
    logic [ADDR_W-1:0] samp_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [KW-1:0]     k_cnt;
    logic [FCNT_W-1:0] f_cnt;
    logic [FCNT_W-1:0] nf_q;
    logic [BW-1:0]     b_cnt;
    logic              cap;

    // Overlapping frames are re-read: the next frame restarts HOP samples after the current frame start.
    assign next_addr = frame_last ? (frame_addr + HOP_STEP) : (samp_addr + SAMP_STEP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_addr   <= '0;
            samp_addr    <= '0;
            k_cnt        <= '0;
            f_cnt        <= '0;
            nf_q         <= '0;
            b_cnt        <= '0;
            cap          <= 1'b0;
            ram_rd       <= 1'b0;
            ram_addr     <= '0;
            sample_valid <= 1'b0;
            frame_first  <= 1'b0;
            frame_last   <= 1'b0;
            done         <= 1'b0;
        end else begin
            cap  <= ram_rd;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nf_q       <= num_frames;
                        frame_addr <= base_addr;
                        samp_addr  <= base_addr;
                        k_cnt      <= '0;
                        f_cnt      <= '0;
                        if (num_frames == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= FETCH;
                            ram_rd   <= 1'b1;
                            ram_addr <= base_addr;
                            b_cnt    <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (b_cnt == BW'(BYTES - 1)) begin
                        ram_rd <= 1'b0;
                        state  <= WAIT_DATA;
                    end else begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                        b_cnt    <= b_cnt + BW'(1);
                    end
                end
                WAIT_DATA: begin
                    sample_valid <= 1'b1;
                    frame_first  <= (k_cnt == '0);
                    frame_last   <= (k_cnt == KW'(FRAME_LEN - 1));
                    state        <= PRESENT;
                end
                PRESENT: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        frame_first  <= 1'b0;
                        frame_last   <= 1'b0;
                        if (frame_last && (f_cnt == nf_q - FCNT_W'(1))) begin
                            state <= DONE;
                        end else begin
                            if (frame_last) begin
                                frame_addr <= next_addr;
                                f_cnt      <= f_cnt + FCNT_W'(1);
                                k_cnt      <= '0;
                            end else begin
                                k_cnt <= k_cnt + KW'(1);
                            end
                            samp_addr <= next_addr;
                            ram_addr  <= next_addr;
                            ram_rd    <= 1'b1;
                            b_cnt     <= '0;
                            state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sample_assembler #(
        .RAM_W (RAM_W),
        .BYTES (BYTES)
    ) u_asm (
        .clk   (clk),
        .reset (reset),
        .load  (cap),
        .din   (ram_datain),
        .dout  (sample_out)
    );

endmodule

// File: tb/tb_frame_feeder.sv
// Randomized bench for frame_feeder: a byte-array RAM plus a queue-based model of the expected
// address stream and sample stream, derived directly from the frame/hop addressing rules.
module tb_frame_feeder;

    localparam int RAM_W     = 8;
    localparam int SAMPLE_W  = 16;
    localparam int ADDR_W    = 16;
    localparam int FRAME_LEN = 4;
    localparam int HOP       = 2;
    localparam int FCNT_W    = 8;
    localparam int BYTES     = SAMPLE_W / RAM_W;

    logic                clk;
    logic                reset;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [FCNT_W-1:0]   num_frames;
    logic                ram_rd;
    logic [ADDR_W-1:0]   ram_addr;
    logic [RAM_W-1:0]    ram_datain;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                sample_ready;
    logic                frame_first;
    logic                frame_last;
    logic                busy;
    logic                done;

    frame_feeder #(
        .RAM_W     (RAM_W),
        .SAMPLE_W  (SAMPLE_W),
        .ADDR_W    (ADDR_W),
        .FRAME_LEN (FRAME_LEN),
        .HOP       (HOP),
        .FCNT_W    (FCNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_frames   (num_frames),
        .ram_rd       (ram_rd),
        .ram_addr     (ram_addr),
        .ram_datain   (ram_datain),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_first  (frame_first),
        .frame_last   (frame_last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (ram_rd) ram_datain <= mem[ram_addr];
        else        ram_datain <= 8'($urandom);
    end

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_a [$];
    logic [15:0] exp_s [$];
    bit          exp_f [$];
    bit          exp_l [$];
    logic [15:0] obs_a [$];
    logic [15:0] obs_s [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic build_model(input logic [15:0] base, input int nf);
        exp_a.delete(); exp_s.delete(); exp_f.delete(); exp_l.delete();
        obs_a.delete(); obs_s.delete();
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                logic [15:0] a;
                a = base + 16'((f * HOP + k) * BYTES);
                exp_a.push_back(a);
                exp_a.push_back(a + 16'd1);
                exp_s.push_back({mem[a + 16'd1], mem[a]});
                exp_f.push_back(k == 0);
                exp_l.push_back(k == FRAME_LEN - 1);
            end
        end
    endtask

    // Caller must be just after a negedge; start is presented for exactly one edge.
    task automatic run_job(input logic [15:0] base, input logic [7:0] nf, input int stall_len);
        int          since, cyc, stall_cnt;
        bit          prev_valid, prev_ready, hs, done_seen, first_rise;
        logic [15:0] prev_sample;
        logic [1:0]  prev_fl;
        build_model(base, int'(nf));
        base_addr  = base;
        num_frames = nf;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        since = 0; cyc = 0; stall_cnt = 0;
        prev_valid = 0; prev_ready = 1; done_seen = 0; first_rise = 1;
        prev_sample = '0; prev_fl = '0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ram_rd) begin
                obs_a.push_back(ram_addr);
                if (exp_a.size() == 0) check("extra_rd", 1, 0);
                else                   check("ram_addr", ram_addr, exp_a.pop_front());
                check("rd_while_valid", sample_valid, 0);
            end
            if (sample_valid && !prev_valid) begin
                check("latency", since, BYTES + 1);
                if (first_rise) stall_cnt = stall_len;
                first_rise = 0;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", sample_valid, 1);
                check("hold_sample", sample_out, prev_sample);
                check("hold_flags", {frame_first, frame_last}, prev_fl);
            end
            sample_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (stall_cnt > 0) stall_cnt--;
            start      = busy && ($urandom_range(0, 7) == 0);
            base_addr  = 16'($urandom);
            num_frames = 8'($urandom);
            hs = sample_valid && sample_ready;
            if (hs) begin
                obs_s.push_back(sample_out);
                if (exp_s.size() == 0) begin
                    check("extra_xfer", 1, 0);
                end else begin
                    check("sample", sample_out, exp_s.pop_front());
                    check("first", frame_first, exp_f.pop_front());
                    check("last", frame_last, exp_l.pop_front());
                end
            end
            if (done) begin
                done_seen = 1;
                check("addr_left", exp_a.size(), 0);
                check("samp_left", exp_s.size(), 0);
            end
            prev_valid  = sample_valid;
            prev_ready  = sample_ready;
            prev_sample = sample_out;
            prev_fl     = {frame_first, frame_last};
            @(posedge clk);
            if (hs) since = 0;
            else    since++;
        end
        check("done_seen", done_seen, 1);
        start        = 1'b0;
        sample_ready = 1'b0;
        @(negedge clk);
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_frames   = '0;
        sample_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h02; mem[1] = 8'h00; mem[2] = 8'h05; mem[3] = 8'h00;
        mem[4] = 8'h07; mem[5] = 8'h00; mem[6] = 8'h09; mem[7] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {ram_rd, ram_addr, sample_out, sample_valid, frame_first,
                              frame_last, busy, done}, '0);
        @(negedge clk);
        reset = 1'b0;

        // Known bytes at address 0: first samples are 0x0002 then 0x0005.
        run_job(16'h0000, 8'd1, 0);
        check("s0_const", obs_s[0], 16'h0002);
        check("s1_const", obs_s[1], 16'h0005);

        // Two overlapping frames: second frame starts HOP samples in (byte 4).
        @(negedge clk);
        run_job(16'h0000, 8'd2, 0);
        check("n_xfer", obs_s.size(), 8);
        check("f1_addr", obs_a[8], 16'h0004);

        // Long stall on the first presented sample.
        @(negedge clk);
        run_job(16'h0100, 8'd1, 10);

        // Address wrap at the top of the space.
        @(negedge clk);
        run_job(16'hFFFE, 8'd1, 0);
        check("wrap_a0", obs_a[0], 16'hFFFE);
        check("wrap_a1", obs_a[1], 16'hFFFF);
        check("wrap_a2", obs_a[2], 16'h0000);
        check("wrap_a3", obs_a[3], 16'h0001);

        // Zero frames: done two cycles after start, no reads.
        @(negedge clk);
        base_addr  = 16'h2222;
        num_frames = 8'd0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("z_done_early", done, 0);
        check("z_rd0", ram_rd, 0);
        @(posedge clk);
        #1;
        check("z_done", done, 1);
        check("z_rd1", ram_rd, 0);
        @(posedge clk);
        #1;
        check("z_done_off", done, 0);

        // Reset in the middle of a fetch, then a fresh job at a new base.
        @(negedge clk);
        base_addr  = 16'h1234;
        num_frames = 8'd1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_rd", ram_rd, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", {ram_rd, ram_addr, sample_out, sample_valid, frame_first,
                                  frame_last, busy, done}, '0);
        @(negedge clk);
        reset = 1'b0;
        run_job(16'h4000, 8'd1, 2);

        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            run_job(16'($urandom), 8'($urandom_range(1, 3)), $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
